// File: rtl/accel_pkg.sv
// Shared types and constants for the inexact-recursion accelerator:
// FSM encoding, descriptor/state-record field layout and widths.
package accel_pkg;

  localparam int AW    = 12;
  localparam int DW_IR = 32;
  localparam int DW_ST = 18;
  localparam int VW    = 16;
  localparam int FW    = 8;

  // Descriptor word layout (all fields FW bits, unsigned).
  localparam int INCR_LSB  = 24;
  localparam int STEP_LSB  = 16;
  localparam int BASE_LSB  = 8;
  localparam int COUNT_LSB = 0;

  // State record layout.
  localparam int VALID_BIT = 17;
  localparam int VALUE_LSB = 1;
  localparam int CARRY_BIT = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEED  = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } fsm_e;

  function automatic logic [DW_ST-1:0] pack_rec(input logic          valid,
                                                input logic [VW-1:0] value,
                                                input logic          carry);
    logic [DW_ST-1:0] r;
    r                   = '0;
    r[VALID_BIT]        = valid;
    r[VALUE_LSB +: VW]  = value;
    r[CARRY_BIT]        = carry;
    return r;
  endfunction

endpackage

// File: rtl/regfile_sp.sv
// Register file with one synchronous write port and two asynchronous read
// ports; used for both the descriptor file and the state file.
module regfile_sp #(
  parameter int W  = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr0_i,
  output logic [W-1:0]  rdata0_o,
  input  logic [AW-1:0] raddr1_i,
  output logic [W-1:0]  rdata1_o
);

  localparam int DEPTH = 2**AW;

  logic [W-1:0] mem_q [DEPTH];

  // NOTE: the array is deliberately left out of reset; clearing thousands of
  // entries would need a reset fan-out to every cell and the host preloads
  // the contents anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/top.sv
// Inexact-recursion accelerator top: descriptor and state register files plus
// the chained-accumulate engine that walks and rewrites state records.
module top
  import accel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             is_start,
  input  logic             ran_we_InexRecur,
  input  logic [AW-1:0]    ran_w_addr_InexRecur,
  input  logic [DW_IR-1:0] ran_w_data_InexRecur,
  input  logic             ran_we_state_external,
  input  logic [AW-1:0]    ran_w_addr_state_external,
  input  logic [DW_ST-1:0] ran_w_data_state_external,
  input  logic [AW-1:0]    dbg_rd_addr_state,
  output logic [DW_ST-1:0] dbg_rd_data_state,
  output logic             busy,
  output logic             done
);

  fsm_e          state_q;
  logic          is_start_q;
  logic          busy_q;
  logic          done_q;
  logic [FW-1:0] incr_q;
  logic [FW-1:0] step_q;
  logic [FW-1:0] base_q;
  logic [FW-1:0] count_q;
  logic [FW-1:0] j_q;
  logic [AW-1:0] a_q;
  logic [VW-1:0] acc_q;

  logic             idle;
  logic             eng_we;
  logic [VW:0]      sum;
  logic [DW_IR-1:0] ir_rd;
  logic [DW_IR-1:0] unused_ir_rd1;
  logic [DW_ST-1:0] st_seed_rd;
  logic             unused_seed_flags;
  logic [AW-1:0]    base_addr;

  logic             st_we_d;
  logic [AW-1:0]    st_waddr_d;
  logic [DW_ST-1:0] st_wdata_d;

  assign idle      = (state_q == IDLE);
  assign sum       = {1'b0, acc_q} + {{(VW+1-FW){1'b0}}, incr_q};
  assign base_addr = {{(AW-FW){1'b0}}, base_q};
  // Reset wins over the in-flight STEP so nothing is written on the reset edge.
  assign eng_we    = (state_q == STEP) && !rst;

  assign unused_seed_flags = st_seed_rd[VALID_BIT] ^ st_seed_rd[CARRY_BIT];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value held and no latch is inferred.
  always_comb begin
    st_we_d    = 1'b0;
    st_waddr_d = ran_w_addr_state_external;
    st_wdata_d = ran_w_data_state_external;
    if (eng_we) begin
      st_we_d    = 1'b1;
      st_waddr_d = a_q;
      st_wdata_d = pack_rec(1'b1, sum[VW-1:0], sum[VW]);
    end else if (idle && ran_we_state_external) begin
      st_we_d    = 1'b1;
    end
  end

  regfile_sp #(.W(DW_IR), .AW(AW)) u_rf_ir (
    .clk      (clk),
    .we_i     (idle && ran_we_InexRecur),
    .waddr_i  (ran_w_addr_InexRecur),
    .wdata_i  (ran_w_data_InexRecur),
    .raddr0_i ('0),
    .rdata0_o (ir_rd),
    .raddr1_i ('0),
    .rdata1_o (unused_ir_rd1)
  );

  regfile_sp #(.W(DW_ST), .AW(AW)) u_rf_state (
    .clk      (clk),
    .we_i     (st_we_d),
    .waddr_i  (st_waddr_d),
    .wdata_i  (st_wdata_d),
    .raddr0_i (base_addr),
    .rdata0_o (st_seed_rd),
    .raddr1_i (dbg_rd_addr_state),
    .rdata1_o (dbg_rd_data_state)
  );

  // NOTE: all state in this clocked block uses non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      incr_q     <= '0;
      step_q     <= '0;
      base_q     <= '0;
      count_q    <= '0;
      j_q        <= '0;
      a_q        <= '0;
      acc_q      <= '0;
    end else begin
      is_start_q <= is_start;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_start && !is_start_q) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          incr_q  <= ir_rd[INCR_LSB  +: FW];
          step_q  <= ir_rd[STEP_LSB  +: FW];
          base_q  <= ir_rd[BASE_LSB  +: FW];
          count_q <= ir_rd[COUNT_LSB +: FW];
          state_q <= SEED;
        end
        SEED: begin
          acc_q <= st_seed_rd[VALUE_LSB +: VW];
          a_q   <= base_addr;
          j_q   <= '0;
          if (count_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= STEP;
          end
        end
        STEP: begin
          acc_q <= sum[VW-1:0];
          a_q   <= a_q + {{(AW-FW){1'b0}}, step_q};
          j_q   <= j_q + 1'b1;
          if (j_q == count_q - 1'b1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_top.sv
// Bench for the accelerator top: directed runs push expected done cycles and
// state records into queues; a monitor checks them when done pulses.
module tb_top;
  import accel_pkg::*;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [DW_ST-1:0] data;
  } mem_exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             is_start;
  logic             ran_we_InexRecur;
  logic [AW-1:0]    ran_w_addr_InexRecur;
  logic [DW_IR-1:0] ran_w_data_InexRecur;
  logic             ran_we_state_external;
  logic [AW-1:0]    ran_w_addr_state_external;
  logic [DW_ST-1:0] ran_w_data_state_external;
  logic [AW-1:0]    dbg_rd_addr_state;
  logic [DW_ST-1:0] dbg_rd_data_state;
  logic             busy;
  logic             done;

  int       n_checks = 0;
  int       n_errors = 0;
  int       cyc      = 0;
  int       exp_done_q[$];
  mem_exp_t exp_mem_q[$];
  bit       flush_req = 1'b0;

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  top dut (
    .clk                       (clk),
    .rst                       (rst),
    .is_start                  (is_start),
    .ran_we_InexRecur          (ran_we_InexRecur),
    .ran_w_addr_InexRecur      (ran_w_addr_InexRecur),
    .ran_w_data_InexRecur      (ran_w_data_InexRecur),
    .ran_we_state_external     (ran_we_state_external),
    .ran_w_addr_state_external (ran_w_addr_state_external),
    .ran_w_data_state_external (ran_w_data_state_external),
    .dbg_rd_addr_state         (dbg_rd_addr_state),
    .dbg_rd_data_state         (dbg_rd_data_state),
    .busy                      (busy),
    .done                      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW_ST-1:0] rec(input logic [15:0] v, input logic c);
    return {1'b1, v, c};
  endfunction

  task automatic expect_mem(input logic [AW-1:0] a, input logic [DW_ST-1:0] d);
    mem_exp_t e;
    e.addr = a;
    e.data = d;
    exp_mem_q.push_back(e);
  endtask

  task automatic drain();
    mem_exp_t e;
    while (exp_mem_q.size() > 0) begin
      e = exp_mem_q.pop_front();
      dbg_rd_addr_state = e.addr;
      #1;
      check($sformatf("state[0x%03h]", e.addr), 32'(dbg_rd_data_state), 32'(e.data));
    end
  endtask

  // Monitor: done pulses are matched against expected cycles, then the
  // queued state records are read back through the debug port.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
        end else begin
          check("done_cycle", cyc, exp_done_q.pop_front());
        end
        drain();
      end else if (flush_req) begin
        drain();
        flush_req = 1'b0;
      end
    end
  end

  task automatic wr_ir(input logic [AW-1:0] a, input logic [DW_IR-1:0] d);
    ran_we_InexRecur     = 1'b1;
    ran_w_addr_InexRecur = a;
    ran_w_data_InexRecur = d;
    @(negedge clk);
    ran_we_InexRecur     = 1'b0;
  endtask

  task automatic wr_state(input logic [AW-1:0] a, input logic [DW_ST-1:0] d);
    ran_we_state_external     = 1'b1;
    ran_w_addr_state_external = a;
    ran_w_data_state_external = d;
    @(negedge clk);
    ran_we_state_external     = 1'b0;
  endtask

  // Raises is_start at a negedge, waits for done, then holds is_start high to
  // confirm the level does not retrigger.
  task automatic run(input int cnt, input bit inject);
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    exp_done_q.push_back(cyc + 3 + cnt);
    is_start = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (inject && i == 0) begin
        ran_we_state_external     = 1'b1;
        ran_w_addr_state_external = 12'h100;
        ran_w_data_state_external = 18'h2AAAA;
        ran_we_InexRecur          = 1'b1;
        ran_w_addr_InexRecur      = 12'h000;
        ran_w_data_InexRecur      = 32'h01_01_00_01;
      end
      if (inject && i == 1) begin
        ran_we_state_external = 1'b0;
        ran_we_InexRecur      = 1'b0;
      end
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
    check("run_completes", 32'(seen), 32'd1);
    check("busy_cycles", busy_n, cnt + 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_retrigger", 32'(busy), 32'd0);
    end
    is_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                       = 1'b1;
    is_start                  = 1'b0;
    ran_we_InexRecur          = 1'b0;
    ran_w_addr_InexRecur      = '0;
    ran_w_data_InexRecur      = '0;
    ran_we_state_external     = 1'b0;
    ran_w_addr_state_external = '0;
    ran_w_data_state_external = '0;
    dbg_rd_addr_state         = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // incr=2 step=1 base=0 count=6, host writes attempted while busy
    wr_ir(12'h000, 32'h02_01_00_06);
    wr_state(12'h000, 18'h00000);
    wr_state(12'h100, 18'h15555);
    for (int k = 0; k < 6; k++) expect_mem(12'(k), rec(16'(2*k+2), 1'b0));
    expect_mem(12'h100, 18'h15555);
    run(6, 1'b1);

    // Same descriptor again: the busy-time descriptor write must not have landed
    for (int k = 0; k < 6; k++) expect_mem(12'(k), rec(16'(2*k+4), 1'b0));
    run(6, 1'b0);

    // count=0: no writes, prior record intact
    wr_state(12'h030, 18'h0ABCD);
    wr_ir(12'h000, 32'h01_01_30_00);
    expect_mem(12'h030, 18'h0ABCD);
    run(0, 1'b0);

    // 16-bit overflow and per-step carry
    wr_ir(12'h000, 32'hFF_03_10_02);
    wr_state(12'h010, {1'b0, 16'hFFF0, 1'b0});
    expect_mem(12'h010, rec(16'h00EF, 1'b1));
    expect_mem(12'h013, rec(16'h01EE, 1'b0));
    run(2, 1'b0);

    // base=0xFF step=0x80
    wr_ir(12'h000, 32'h01_80_FF_03);
    wr_state(12'h0FF, 18'h00000);
    expect_mem(12'h0FF, rec(16'd1, 1'b0));
    expect_mem(12'h17F, rec(16'd2, 1'b0));
    expect_mem(12'h1FF, rec(16'd3, 1'b0));
    run(3, 1'b0);

    // Address wraps past 0xFFF on the 17th step
    wr_ir(12'h000, 32'h10_FF_FF_11);
    wr_state(12'h0FF, 18'h00000);
    for (int k = 0; k < 17; k++) expect_mem(12'((k+1)*255), rec(16'((k+1)*16), 1'b0));
    run(17, 1'b0);

    // step=0 rewrites base every step
    wr_ir(12'h000, 32'h03_00_05_04);
    wr_state(12'h005, {1'b0, 16'd10, 1'b0});
    expect_mem(12'h005, rec(16'd22, 1'b0));
    run(4, 1'b0);

    // Reset in the middle of the STEP phase
    wr_ir(12'h000, 32'h01_01_20_0A);
    wr_state(12'h020, {1'b0, 16'd5, 1'b0});
    wr_state(12'h023, 18'h00777);
    is_start = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    rst      = 1'b1;
    is_start = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_mem(12'h020, rec(16'd6, 1'b0));
    expect_mem(12'h021, rec(16'd7, 1'b0));
    expect_mem(12'h023, 18'h00777);
    flush_req = 1'b1;
    for (int i = 0; i < 10 && flush_req; i++) @(negedge clk);
    check("flush_done", 32'(flush_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_rst", 32'(busy), 32'd0);
    end

    check("pending_done", exp_done_q.size(), 32'd0);
    check("pending_mem", exp_mem_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
